// File: rtl/counter_mon_pkg.sv
// Shared types, default widths and the upstream-counter prediction helper
// for counter_overflow_monitor.
package counter_mon_pkg;

    localparam int unsigned CNT_W_DEF  = 4;
    localparam int unsigned EXT_W_DEF  = 16;
    localparam int unsigned WRAP_W_DEF = 8;
    localparam int unsigned ERR_W      = 8;
    localparam int unsigned MAX_CNT_W  = 32;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } mon_state_t;

    typedef struct packed {
        logic [MAX_CNT_W-1:0] cnt;
        logic                 ovf;
    } expect_t;

    // Predicts the next upstream value and overflow flag for a cnt_w-bit counter.
    function automatic expect_t next_expected(input logic [MAX_CNT_W-1:0] prev,
                                              input logic                 en,
                                              input int unsigned          cnt_w);
        logic [MAX_CNT_W:0]   span_s;
        logic [MAX_CNT_W-1:0] mask_s;
        expect_t              res_s;
        span_s    = ({{MAX_CNT_W{1'b0}}, 1'b1} << cnt_w) - {{MAX_CNT_W{1'b0}}, 1'b1};
        mask_s    = span_s[MAX_CNT_W-1:0];
        res_s.cnt = en ? ((prev + {{(MAX_CNT_W-1){1'b0}}, 1'b1}) & mask_s) : (prev & mask_s);
        res_s.ovf = en && ((prev & mask_s) == mask_s);
        return res_s;
    endfunction

endpackage

// File: rtl/counter_overflow_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    // Count register: clear beats increment, increment stops at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {W{1'b0}};
        end else if (clear) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/counter_overflow_monitor.sv
// Protocol monitor for an enable-gated up-counter; rebuilds a wide count.
// MON_ERR_COUNT_EN adds err_count_out and makes faults self-resyncing.
module counter_overflow_monitor
    import counter_mon_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned EXT_W  = EXT_W_DEF,
    parameter int unsigned WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_in,
    input  logic [CNT_W-1:0]  counter_in,
    input  logic              overflow_in,
    input  logic              clear_in,
    output logic [EXT_W-1:0]  ext_count_out,
    output logic [WRAP_W-1:0] wraps_out,
    output logic              mismatch_out,
    output logic              fault_out,
`ifdef MON_ERR_COUNT_EN
    output logic [ERR_W-1:0]  err_count_out,
`endif
    output logic [1:0]        state_out
);

    mon_state_t       state_r;
    logic [CNT_W-1:0] prev_cnt_r;
    logic             en_q_r;

    expect_t          exp_s;
    logic             match_s;
    logic             track_s;
    logic             bad_s;
    logic             wrap_inc_s;

    // Compare the live sample against what the previous sample predicts.
    always_comb begin
        exp_s      = next_expected(MAX_CNT_W'(prev_cnt_r), en_q_r, CNT_W);
        match_s    = (MAX_CNT_W'(counter_in) == exp_s.cnt) && (overflow_in == exp_s.ovf);
        track_s    = (state_r == TRACK) && !clear_in;
        bad_s      = track_s && !match_s;
        wrap_inc_s = track_s && match_s && exp_s.ovf;
    end

    // Tracking FSM with its registered outputs; a clear always wins over a violation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= SYNC;
            prev_cnt_r    <= {CNT_W{1'b0}};
            en_q_r        <= 1'b0;
            ext_count_out <= {EXT_W{1'b0}};
            mismatch_out  <= 1'b0;
            fault_out     <= 1'b0;
        end else begin
            prev_cnt_r   <= counter_in;
            en_q_r       <= enable_in;
            mismatch_out <= 1'b0;
            case (state_r)
                SYNC: begin
                    ext_count_out <= {{(EXT_W-CNT_W){1'b0}}, counter_in};
                    state_r       <= TRACK;
                end
                TRACK: begin
                    if (clear_in) begin
                        state_r <= SYNC;
                    end else if (match_s) begin
                        if (en_q_r) begin
                            ext_count_out <= ext_count_out + {{(EXT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        mismatch_out <= 1'b1;
                        fault_out    <= 1'b1;
`ifdef MON_ERR_COUNT_EN
                        state_r      <= SYNC;
`else
                        state_r      <= FAULT;
`endif
                    end
                end
                FAULT: begin
                    if (clear_in) begin
                        state_r   <= SYNC;
                        fault_out <= 1'b0;
                    end else begin
                        fault_out <= 1'b1;
                    end
                end
                default: begin
                    state_r <= SYNC;
                end
            endcase
`ifdef MON_ERR_COUNT_EN
            // Error history stays latched across resyncs until explicitly cleared.
            if (clear_in) begin
                fault_out <= 1'b0;
            end
`endif
        end
    end

    assign state_out = state_r;

    sat_counter #(.W(WRAP_W)) u_wraps (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_inc_s),
        .clear (1'b0),
        .count (wraps_out)
    );

`ifdef MON_ERR_COUNT_EN
    sat_counter #(.W(ERR_W)) u_errs (
        .clk   (clk),
        .reset (reset),
        .inc   (bad_s),
        .clear (1'b0),
        .count (err_count_out)
    );
`else
    logic unused_bad_s;
    assign unused_bad_s = bad_s;
`endif

endmodule

// File: tb/tb_counter_overflow_monitor.sv
// Scoreboard bench for counter_overflow_monitor (either MON_ERR_COUNT_EN build).
module tb_counter_overflow_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_in;
    logic [3:0]  counter_in;
    logic        overflow_in;
    logic        clear_in;
    logic [15:0] ext_count_out;
    logic [7:0]  wraps_out;
    logic        mismatch_out;
    logic        fault_out;
    logic [1:0]  state_out;
`ifdef MON_ERR_COUNT_EN
    logic [7:0]  err_count_out;
`endif

    typedef struct {
        int    ext;
        int    wraps;
        int    mis;
        int    fault;
        int    state;
        int    err;
        string tag;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] up_cnt;
    logic       up_ovf;
    int         err_exp;

    counter_overflow_monitor dut (
        .clk           (clk),
        .reset         (reset),
        .enable_in     (enable_in),
        .counter_in    (counter_in),
        .overflow_in   (overflow_in),
        .clear_in      (clear_in),
        .ext_count_out (ext_count_out),
        .wraps_out     (wraps_out),
        .mismatch_out  (mismatch_out),
        .fault_out     (fault_out),
`ifdef MON_ERR_COUNT_EN
        .err_count_out (err_count_out),
`endif
        .state_out     (state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per clock, compared on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.tag, ".ext"},   32'(ext_count_out), e.ext);
            chk({e.tag, ".wraps"}, 32'(wraps_out),     e.wraps);
            chk({e.tag, ".mis"},   32'(mismatch_out),  e.mis);
            chk({e.tag, ".fault"}, 32'(fault_out),     e.fault);
            chk({e.tag, ".state"}, 32'(state_out),     e.state);
`ifdef MON_ERR_COUNT_EN
            chk({e.tag, ".err"},   32'(err_count_out), e.err);
`endif
        end
    end

    // Drive one clock of upstream activity and queue the expected outputs after it.
    task automatic step(input logic en, input logic clr, input int x_ext, input int x_wr,
                        input int x_mis, input int x_fault, input int x_st, input string tag);
        exp_t e;
        enable_in   = en;
        counter_in  = up_cnt;
        overflow_in = up_ovf;
        clear_in    = clr;
        @(posedge clk);
        e.ext = x_ext; e.wraps = x_wr; e.mis = x_mis; e.fault = x_fault;
        e.state = x_st; e.err = err_exp; e.tag = tag;
        sb_q.push_back(e);
        #1;
        up_ovf = en && (up_cnt == 4'd15);
        if (en) up_cnt = up_cnt + 4'd1;
    endtask

    // Asynchronous reset between edges, checked before the next clock.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        enable_in = 1'b0; counter_in = 4'd0; overflow_in = 1'b0; clear_in = 1'b0;
        up_cnt = 4'd0; up_ovf = 1'b0; err_exp = 0;
        #1;
        chk("reset.ext",   32'(ext_count_out), 0);
        chk("reset.wraps", 32'(wraps_out),     0);
        chk("reset.mis",   32'(mismatch_out),  0);
        chk("reset.fault", 32'(fault_out),     0);
        chk("reset.state", 32'(state_out),     0);
`ifdef MON_ERR_COUNT_EN
        chk("reset.err",   32'(err_count_out), 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable_in = 1'b0; counter_in = 4'd0; overflow_in = 1'b0; clear_in = 1'b0;
        up_cnt = 4'd0; up_ovf = 1'b0; err_exp = 0;
        do_reset();

        // Continuous counting through one wrap.
        for (int n = 1; n <= 21; n++) step(1'b1, 1'b0, n - 1, (n >= 17) ? 1 : 0, 0, 0, 1, "count");

        // Enable toggling: only enabled cycles advance the extended count.
        step(1'b0, 1'b0, 21, 1, 0, 0, 1, "tog0");
        step(1'b1, 1'b0, 21, 1, 0, 0, 1, "tog1");
        step(1'b0, 1'b0, 22, 1, 0, 0, 1, "tog2");
        step(1'b1, 1'b0, 22, 1, 0, 0, 1, "tog3");
        step(1'b0, 1'b0, 23, 1, 0, 0, 1, "tog4");

        // Reset asserted asynchronously with ext_count_out at 9.
        do_reset();
        for (int n = 1; n <= 10; n++) step(1'b1, 1'b0, n - 1, 0, 0, 0, 1, "pre-rst");
        do_reset();

        // Skip from 5 to 7.
        for (int n = 1; n <= 6; n++) step(1'b1, 1'b0, n - 1, 0, 0, 0, 1, "pre-skip");
        up_cnt = 4'd7;
`ifdef MON_ERR_COUNT_EN
        err_exp = 1;
        step(1'b1, 1'b0, 5,  0, 1, 1, 0, "skip");
        step(1'b1, 1'b0, 8,  0, 0, 1, 1, "skip-resync");
        step(1'b1, 1'b1, 8,  0, 0, 0, 0, "skip-clear");
`else
        step(1'b1, 1'b0, 5,  0, 1, 1, 2, "skip");
        step(1'b1, 1'b0, 5,  0, 0, 1, 2, "skip-frozen");
        step(1'b1, 1'b1, 5,  0, 0, 0, 0, "skip-clear");
`endif
        step(1'b1, 1'b0, 10, 0, 0, 0, 1, "skip-sync");
        step(1'b1, 1'b0, 11, 0, 0, 0, 1, "skip-track");

        // Spurious overflow at 3, then a missing overflow on the 15 -> 0 wrap.
        do_reset();
        for (int n = 1; n <= 3; n++) step(1'b1, 1'b0, n - 1, 0, 0, 0, 1, "pre-ovf");
        up_ovf = 1'b1;
`ifdef MON_ERR_COUNT_EN
        err_exp = 1;
        step(1'b1, 1'b0, 2, 0, 1, 1, 0, "spur-ovf");
        step(1'b1, 1'b0, 4, 0, 0, 1, 1, "spur-resync");
        for (int v = 5; v <= 15; v++) step(1'b1, 1'b0, v, 0, 0, 1, 1, "ovf-track");
        up_ovf = 1'b0;
        err_exp = 2;
        step(1'b1, 1'b0, 15, 0, 1, 1, 0, "miss-ovf");
        step(1'b1, 1'b0, 1,  0, 0, 1, 1, "miss-resync");
        step(1'b1, 1'b0, 2,  0, 0, 1, 1, "miss-resume");
`else
        step(1'b1, 1'b0, 2, 0, 1, 1, 2, "spur-ovf");
        step(1'b1, 1'b1, 2, 0, 0, 0, 0, "spur-clear");
        step(1'b1, 1'b0, 5, 0, 0, 0, 1, "spur-sync");
        for (int v = 6; v <= 15; v++) step(1'b1, 1'b0, v, 0, 0, 0, 1, "ovf-track");
        up_ovf = 1'b0;
        step(1'b1, 1'b0, 15, 0, 1, 1, 2, "miss-ovf");
        step(1'b1, 1'b0, 15, 0, 0, 1, 2, "miss-frozen");
`endif

        // Long run: wraps_out saturates, ext_count_out rolls over 16 bits.
        do_reset();
        for (int n = 1; n <= 65556; n++) begin
            int m;
            m = n - 1;
            step(1'b1, 1'b0, m % 65536, (m / 16 > 255) ? 255 : m / 16, 0, 0, 1, "sat");
        end

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d records left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
